// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M
// multiply/divide sequencer.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    modport master (output start, op, rs1, rs2, kill, input busy, valid, result);
    modport slave  (input start, op, rs1, rs2, kill, output busy, valid, result);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shift/add-subtract bit per
// cycle on operand magnitudes, followed by a single sign fix-up cycle.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] x);
        return ~x + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [4:0]        cnt_r;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   opnd_r;
    logic [2*XLEN-1:0] acc_r;
    logic              sign_r;
    logic              rneg_r;
    logic [XLEN-1:0]   result_r;

    logic              a_signed_s;
    logic              b_signed_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              div0_s;
    logic              ovf_s;
    logic              special_s;
    logic [XLEN-1:0]   special_res_s;
    logic              accept_s;
    logic [2*XLEN-1:0] acc_init_s;
    logic [XLEN-1:0]   opnd_init_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   div_rem_s;
    logic [2*XLEN-1:0] acc_step_s;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res_s;

    // Operand signedness and magnitudes for the incoming request
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (bus.op)
            OP_MULH: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            OP_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            OP_DIV, OP_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        a_neg_s = a_signed_s & bus.rs1[XLEN-1];
        b_neg_s = b_signed_s & bus.rs2[XLEN-1];
        if (a_neg_s) a_mag_s = neg_w(bus.rs1);
        else         a_mag_s = bus.rs1;
        if (b_neg_s) b_mag_s = neg_w(bus.rs2);
        else         b_mag_s = bus.rs2;
    end

    // Request acceptance, special-case detection and datapath load values
    always_comb begin
        div0_s    = bus.op[2] && (bus.rs2 == ZERO);
        ovf_s     = bus.op[2] && !bus.op[0] && (bus.rs1 == INT_MIN) && (bus.rs2 == ALL_ONES);
        special_s = div0_s || ovf_s;
        // op[1] separates REM/REMU from DIV/DIVU
        if (div0_s)     special_res_s = bus.op[1] ? bus.rs1 : ALL_ONES;
        else if (ovf_s) special_res_s = bus.op[1] ? ZERO : INT_MIN;
        else            special_res_s = ZERO;
        accept_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && bus.start && !bus.kill;
        // Divide shifts the dividend out of the low word; multiply shifts the multiplier
        if (bus.op[2]) begin
            acc_init_s  = {ZERO, a_mag_s};
            opnd_init_s = b_mag_s;
        end else begin
            acc_init_s  = {ZERO, b_mag_s};
            opnd_init_s = a_mag_s;
        end
    end

    // One radix-2 iteration: shift-add multiply or restoring divide
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, (acc_r[0] ? opnd_r : ZERO)};
        div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        if (div_ge_s) div_rem_s = div_shift_s[XLEN-1:0] - opnd_r;
        else          div_rem_s = div_shift_s[XLEN-1:0];
        if (op_r[2]) acc_step_s = {div_rem_s, acc_r[XLEN-2:0], div_ge_s};
        else         acc_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end

    // Sign correction and result select applied in the fix-up cycle
    always_comb begin
        if (sign_r) prod_s = neg_dw(acc_r);
        else        prod_s = acc_r;
        if (sign_r) quo_s = neg_w(acc_r[XLEN-1:0]);
        else        quo_s = acc_r[XLEN-1:0];
        if (rneg_r) rem_s = neg_w(acc_r[2*XLEN-1:XLEN]);
        else        rem_s = acc_r[2*XLEN-1:XLEN];
        case (op_r)
            OP_MUL:                       fix_res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_s = quo_s;
            OP_REM, OP_REMU:              fix_res_s = rem_s;
            default:                      fix_res_s = ZERO;
        endcase
    end

    // Next-state decode; kill wins over everything except reset
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) state_next_s = special_s ? ST_DONE : ST_CALC;
                else          state_next_s = ST_IDLE;
            end
            ST_CALC: begin
                if (bus.kill)            state_next_s = ST_IDLE;
                else if (cnt_r == 5'd0)  state_next_s = ST_FIX;
                else                     state_next_s = ST_CALC;
            end
            ST_FIX: begin
                if (bus.kill) state_next_s = ST_IDLE;
                else          state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 5'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s)                                 cnt_r <= 5'd31;
            else if ((state_r == ST_CALC) && (cnt_r != 5'd0)) cnt_r <= cnt_r - 5'd1;
            else                                          cnt_r <= cnt_r;
        end
    end

    // Operand capture at the start edge and accumulator iteration in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= 3'd0;
            opnd_r <= ZERO;
            acc_r  <= {ZERO, ZERO};
            sign_r <= 1'b0;
            rneg_r <= 1'b0;
        end else if (accept_s && !special_s) begin
            op_r   <= bus.op;
            opnd_r <= opnd_init_s;
            acc_r  <= acc_init_s;
            sign_r <= a_neg_s ^ b_neg_s;
            rneg_r <= a_neg_s;
        end else if ((state_r == ST_CALC) && !bus.kill) begin
            acc_r <= acc_step_s;
        end
    end

    // Result register: loaded only by a special-case start or FIX->DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= ZERO;
        end else if (accept_s && special_s) begin
            result_r <= special_res_s;
        end else if ((state_r == ST_FIX) && !bus.kill) begin
            result_r <= fix_res_s;
        end
    end

    assign bus.busy   = (state_r == ST_CALC) || (state_r == ST_FIX);
    assign bus.valid  = (state_r == ST_DONE);
    assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases, special cases,
// kill/reset behaviour, back-to-back starts and randomized operations.
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    muldiv_if bus();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Waits for valid with start already driven; lat = -1 on timeout
    task automatic wait_valid(output logic [31:0] res, output int lat, output int busyc);
        lat = -1; busyc = 0; res = 32'd0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busyc++;
            if (bus.valid) begin
                lat = k; res = bus.result;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busyc);
        bus.op = o; bus.rs1 = a; bus.rs2 = b; bus.start = 1'b1;
        wait_valid(res, lat, busyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.kill = 1'b0;
        bus.op = 3'd0; bus.rs1 = 32'd0; bus.rs2 = 32'd0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got busy %b valid %b exp 0 0", bus.busy, bus.valid);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [8];
        logic [31:0] t_a [8], t_b [8], t_e [8];
        logic [31:0] res; int lat, busyc;
        t_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
        t_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        t_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7};
        t_e  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run_op(t_op[i], t_a[i], t_b[i], res, lat, busyc);
            checks++; if (res !== t_e[i]) begin errors++; $display("FAIL dir_result[%0d] got %h exp %h", i, res, t_e[i]); end
            checks++; if (lat != 34) begin errors++; $display("FAIL dir_latency[%0d] got %0d exp 34", i, lat); end
            checks++; if (busyc != 33) begin errors++; $display("FAIL dir_busy[%0d] got %0d exp 33", i, busyc); end
        end
        @(negedge clk);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b exp 0", bus.valid); end
    endtask

    task automatic test_special();
        logic [2:0]  t_op [4];
        logic [31:0] t_a [4], t_b [4], t_e [4];
        logic [31:0] res; int lat, busyc;
        t_op = '{3'd5, 3'd6, 3'd4, 3'd6};
        t_a  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        t_b  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_e  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_op(t_op[i], t_a[i], t_b[i], res, lat, busyc);
            checks++; if (res !== t_e[i]) begin errors++; $display("FAIL spc_result[%0d] got %h exp %h", i, res, t_e[i]); end
            checks++; if (lat != 1) begin errors++; $display("FAIL spc_latency[%0d] got %0d exp 1", i, lat); end
            checks++; if (busyc != 0) begin errors++; $display("FAIL spc_busy[%0d] got %0d exp 0", i, busyc); end
            @(negedge clk);
            checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL spc_pulse[%0d] got %b exp 0", i, bus.valid); end
        end
    endtask

    // kill together with start in IDLE drops the start; last result was 0
    task automatic test_kill_idle();
        @(negedge clk);
        bus.op = 3'd5; bus.rs1 = 32'd9; bus.rs2 = 32'd0; bus.start = 1'b1; bus.kill = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.kill = 1'b0;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL kill_idle_valid got %b exp 0", bus.valid); end
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL kill_idle_result got %h exp 0", bus.result); end
        bus.op = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd4; bus.start = 1'b1; bus.kill = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.kill = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL kill_idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_kill();
        logic [31:0] res; int lat, busyc; bit vseen;
        @(negedge clk);
        run_op(3'd5, 32'd100, 32'd7, res, lat, busyc);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL kill_pre got %h exp 0000000e", res); end
        @(negedge clk);
        bus.op = 3'd4; bus.rs1 = 32'hFFFF_FC18; bus.rs2 = 32'd3; bus.start = 1'b1;
        repeat (10) begin @(negedge clk); bus.start = 1'b0; end
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL kill_idle_next got busy %b valid %b exp 0 0", bus.busy, bus.valid);
        end
        vseen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.valid) vseen = 1'b1; end
        checks++; if (vseen) begin errors++; $display("FAIL kill_no_valid got valid pulse exp none"); end
        checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL kill_result got %h exp 0000000e", bus.result); end
        run_op(3'd0, 32'd3, 32'd4, res, lat, busyc);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL kill_then_mul got %h exp 0000000c", res); end
        checks++; if (lat != 34) begin errors++; $display("FAIL kill_then_lat got %0d exp 34", lat); end
    endtask

    // A second start during CALC must not disturb the running operation
    task automatic test_start_ignored();
        int lat; logic [31:0] res;
        @(negedge clk);
        bus.op = 3'd0; bus.rs1 = 32'd1000; bus.rs2 = 32'd1000; bus.start = 1'b1;
        lat = -1; res = 32'd0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 5) begin
                bus.op = 3'd5; bus.rs1 = 32'd50; bus.rs2 = 32'd0; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.valid) begin lat = k; res = bus.result; break; end
        end
        checks++; if (res !== 32'd1000000) begin errors++; $display("FAIL ign_result got %h exp 000f4240", res); end
        checks++; if (lat != 34) begin errors++; $display("FAIL ign_latency got %0d exp 34", lat); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.op = 3'd0; bus.rs1 = 32'd5; bus.rs2 = 32'd6; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b exp 1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.valid); end
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL mid_rst_result got %h exp 0", bus.result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o [3];
        logic [31:0] a [3], b [3];
        logic [31:0] res; int lat, busyc;
        o = '{3'd1, 3'd4, 3'd7};
        a = '{$urandom, $urandom, $urandom};
        b = '{$urandom, ($urandom | 32'd1), 32'd0};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            run_op(o[i], a[i], b[i], res, lat, busyc);
            checks++; if (res !== model(o[i], a[i], b[i])) begin
                errors++; $display("FAIL b2b_result[%0d] got %h exp %h", i, res, model(o[i], a[i], b[i]));
            end
            checks++; if (lat != (is_special(o[i], a[i], b[i]) ? 1 : 34)) begin
                errors++; $display("FAIL b2b_latency[%0d] got %0d", i, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] o; logic [31:0] a, b, res; int lat, busyc, elat;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7)); a = pick(); b = pick();
            elat = is_special(o, a, b) ? 1 : 34;
            @(negedge clk);
            run_op(o, a, b, res, lat, busyc);
            checks++; if (res !== model(o, a, b)) begin
                errors++; $display("FAIL rnd_result op %0d a %h b %h got %h exp %h", o, a, b, res, model(o, a, b));
            end
            checks++; if (lat != elat) begin
                errors++; $display("FAIL rnd_latency op %0d got %0d exp %0d", o, lat, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_kill_idle();
        test_kill();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
